// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and encodings for the MEM stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [3:0] BN_BYTE = 4'b0001;
  localparam logic [3:0] BN_HALF = 4'b0011;
  localparam logic [3:0] BN_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP
  } lsu_state_e;

  typedef struct packed {
    logic [1:0]        wb_sel;
    logic              mem_wren;
    logic [3:0]        byte_num;
    logic              ld_unsigned;
    logic              rd_wren;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] rs2_forward;
  } EX_MEM_ff;

  typedef struct packed {
    logic              rd_wren;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
  } MEM_WB_ff;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane alignment: store shift/byte enables and load extract/extend.
module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      off,
  input  logic [3:0]      byte_num,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;

  // Lanes pushed past bit 3 / bit XLEN-1 are simply lost (no split access).
  assign be      = byte_num << off;
  assign wdata   = st_data << {off, 3'b000};
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (byte_num)
      BN_BYTE: ld_data = {{(XLEN-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
      BN_HALF: ld_data = {{(XLEN-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage LSU: req/gnt/rvalid bus handshake, stall generation and MEM/WB register.
// Optional misaligned-access trap via LSU_MISALIGN_CHK_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter logic [1:0]  WB_MEM_SEL = WB_MEM
) (
  input  logic            clk_i,
  input  logic            synclr_ni,
  input  EX_MEM_ff        MEM_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output MEM_WB_ff        WB_o
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic            misalign_o
`endif
);

  lsu_state_e      state, state_nxt;
  logic            mem_op, access, done, drop;
  logic [1:0]      off;
  logic [XLEN-1:0] ld_data;
  MEM_WB_ff        wb_nxt;

  assign off    = MEM_i.alu_data[1:0];
  assign mem_op = MEM_i.mem_wren | (MEM_i.wb_sel == WB_MEM_SEL);

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign;
  assign misalign   = mem_op & (((MEM_i.byte_num == BN_HALF) & off[0]) |
                                ((MEM_i.byte_num == BN_WORD) & (off != 2'b00)));
  assign access     = mem_op & ~misalign;
  assign misalign_o = misalign;
  assign drop       = stall_o | misalign;
`else
  assign access = mem_op;
  assign drop   = stall_o;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .off         (off),
    .byte_num    (MEM_i.byte_num),
    .ld_unsigned (MEM_i.ld_unsigned),
    .st_data     (MEM_i.rs2_forward),
    .rdata       (dmem_rdata_i),
    .be          (dmem_be_o),
    .wdata       (dmem_wdata_o),
    .ld_data     (ld_data)
  );

  assign dmem_we_o   = MEM_i.mem_wren;
  assign dmem_addr_o = {MEM_i.alu_data[XLEN-1:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (!synclr_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WAIT_GNT: begin
        if (!access)         state_nxt = IDLE;
        else if (dmem_gnt_i) state_nxt = MEM_i.mem_wren ? IDLE : WAIT_RSP;
        else                 state_nxt = WAIT_GNT;
      end
      WAIT_RSP: if (dmem_rvalid_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, WAIT_GNT: begin
        dmem_req_o = access;
        done       = access & dmem_gnt_i & MEM_i.mem_wren;
      end
      WAIT_RSP: done = dmem_rvalid_i;
      default:  done = 1'b0;
    endcase
    stall_o = access & ~done;
  end

  always_comb begin
    wb_nxt = '0;
    if (!drop) begin
      wb_nxt.rd_wren = MEM_i.rd_wren;
      wb_nxt.rd_addr = MEM_i.rd_addr;
      if (MEM_i.wb_sel == WB_MEM_SEL)  wb_nxt.rd_data = ld_data;
      else if (MEM_i.wb_sel == WB_PC4) wb_nxt.rd_data = MEM_i.pc4;
      else                             wb_nxt.rd_data = MEM_i.alu_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!synclr_ni) WB_o <= '0;
    else            WB_o <= wb_nxt;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: transaction-level model plus literal spot checks.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  EX_MEM_ff    mem;
  logic        stall, req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  MEM_WB_ff    wb;
`ifdef LSU_MISALIGN_CHK_EN
  logic        mis_o;
`endif

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .WB_MEM_SEL(WB_MEM)) dut (
    .clk_i        (clk),
    .synclr_ni    (rstn),
    .MEM_i        (mem),
    .stall_o      (stall),
    .dmem_req_o   (req),
    .dmem_we_o    (we),
    .dmem_addr_o  (addr),
    .dmem_be_o    (be),
    .dmem_wdata_o (wdata),
    .dmem_gnt_i   (gnt),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i (rdata),
    .WB_o         (wb)
`ifdef LSU_MISALIGN_CHK_EN
    ,
    .misalign_o   (mis_o)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic run = 1'b0;

  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  MEM_WB_ff    exp_wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [3:0] bn);
    if (bn == BN_BYTE) return 1;
    if (bn == BN_HALF) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input EX_MEM_ff op, input logic [31:0] rd);
    int unsigned off = op.alu_data[1:0];
    int          sz  = size_of(op.byte_num);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    logic [31:0] v = (rd >> (8 * off)) & mask;
    if (!op.ld_unsigned && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input EX_MEM_ff op);
    int off = int'(op.alu_data[1:0]);
    int sz  = size_of(op.byte_num);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i - off < sz);
    return r;
  endfunction

  function automatic logic is_mis(input EX_MEM_ff op);
`ifdef LSU_MISALIGN_CHK_EN
    int sz = size_of(op.byte_num);
    logic memop = op.mem_wren | (op.wb_sel == WB_MEM);
    return memop && ((sz == 2 && op.alu_data[0]) || (sz == 4 && op.alu_data[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic EX_MEM_ff mk(input logic [1:0] sel, input logic wren, input logic [3:0] bn,
                                  input logic uns, input logic [4:0] rda, input logic [31:0] pc4,
                                  input logic [31:0] alu, input logic [31:0] rs2);
    EX_MEM_ff o;
    o.wb_sel = sel; o.mem_wren = wren; o.byte_num = bn; o.ld_unsigned = uns;
    o.rd_wren = !wren; o.rd_addr = rda; o.pc4 = pc4; o.alu_data = alu; o.rs2_forward = rs2;
    return o;
  endfunction

  // Write-back model: what the MEM/WB register must hold after each edge.
  always @(posedge clk) begin
    if (!rstn) exp_wb = '0;
    else if (exp_stall || exp_mis) exp_wb = '0;
    else begin
      exp_wb.rd_wren = mem.rd_wren;
      exp_wb.rd_addr = mem.rd_addr;
      if (mem.wb_sel == WB_MEM)      exp_wb.rd_data = model_load(mem, rdata);
      else if (mem.wb_sel == WB_PC4) exp_wb.rd_data = mem.pc4;
      else                           exp_wb.rd_data = mem.alu_data;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("req", {31'd0, req}, {31'd0, exp_req});
      if (exp_req) begin
        chk("addr", addr, exp_addr);
        chk("be", {28'd0, be}, {28'd0, exp_be});
        chk("wdata", wdata, exp_wdata);
        chk("we", {31'd0, we}, {31'd0, mem.mem_wren});
      end
`ifdef LSU_MISALIGN_CHK_EN
      chk("misalign", {31'd0, mis_o}, {31'd0, exp_mis});
`endif
      chk("wb_wren", {31'd0, wb.rd_wren}, {31'd0, exp_wb.rd_wren});
      if (exp_wb.rd_wren) begin
        chk("wb_addr", {27'd0, wb.rd_addr}, {27'd0, exp_wb.rd_addr});
        chk("wb_data", wb.rd_data, exp_wb.rd_data);
      end
    end
  end

  // One transaction: gnt arrives g cycles in, rvalid r cycles after gnt (loads).
  task automatic txn(input EX_MEM_ff op, input int g, input int r, input logic [31:0] rd,
                     output int stalls, output logic [31:0] a0, output logic [3:0] b0,
                     output logic [31:0] w0);
    logic memop = (op.mem_wren | (op.wb_sel == WB_MEM)) && !is_mis(op);
    logic ld    = memop && !op.mem_wren;
    int   last  = !memop ? 0 : (op.mem_wren ? g : g + r);
    stalls = 0;
    for (int c = 0; c <= last; c++) begin
      mem       = op;
      rdata     = rd;
      gnt       = memop && (c == g);
      rvalid    = ld && (c == g + r);
      exp_stall = memop && (c < last);
      exp_req   = memop && (c <= g);
      exp_mis   = is_mis(op);
      exp_addr  = {op.alu_data[31:2], 2'b00};
      exp_be    = model_be(op);
      exp_wdata = op.rs2_forward << (8 * int'(op.alu_data[1:0]));
      @(negedge clk);
      if (stall) stalls++;
      if (c == 0) begin a0 = addr; b0 = be; w0 = wdata; end
      @(posedge clk); #1;
    end
    gnt = 1'b0; rvalid = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0;
  endtask

  initial begin
    int          st;
    logic [31:0] a, w;
    logic [3:0]  b;
    rstn = 1'b0; mem = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    chk("reset_wb", wb, 32'd0);
    rstn = 1'b1;

    txn(mk(WB_PC4, 1'b0, BN_WORD, 1'b0, 5'd5, 32'h44, 32'h0, 32'h0), 0, 0, 32'h0, st, a, w, b);
    chk("pc4_data", wb.rd_data, 32'h44);
    chk("pc4_stall", st, 0);

    txn(mk(WB_ALU, 1'b1, BN_BYTE, 1'b0, 5'd0, 32'h0, 32'h103, 32'hAB), 0, 0, 32'h0, st, a, b, w);
    chk("sb_addr", a, 32'h100);
    chk("sb_be", {28'd0, b}, 32'h8);
    chk("sb_wdata", w, 32'hAB00_0000);
    chk("sb_stall", st, 0);

    txn(mk(WB_MEM, 1'b0, BN_HALF, 1'b0, 5'd7, 32'h0, 32'h202, 32'h0), 0, 2, 32'h8001_1234, st, a, b, w);
    chk("lh_stall", st, 2);
    chk("lh_data", wb.rd_data, 32'hFFFF_8001);
    chk("lh_wren", {31'd0, wb.rd_wren}, 32'd1);

    txn(mk(WB_MEM, 1'b0, BN_BYTE, 1'b1, 5'd8, 32'h0, 32'h401, 32'h0), 0, 1, 32'h0000_F000, st, a, b, w);
    chk("lbu_data", wb.rd_data, 32'h0000_00F0);

    txn(mk(WB_ALU, 1'b1, BN_HALF, 1'b0, 5'd0, 32'h0, 32'h56, 32'hCAFE_BEEF), 3, 0, 32'h0, st, a, b, w);
    chk("sh_wait_stall", st, 3);
    chk("sh_be", {28'd0, b}, 32'hC);

    txn(mk(WB_ALU, 1'b0, BN_WORD, 1'b0, 5'd9, 32'h0, 32'h1234, 32'h0), 0, 0, 32'h0, st, a, b, w);
    chk("alu_data", wb.rd_data, 32'h1234);

    txn(mk(WB_MEM, 1'b0, BN_BYTE, 1'b0, 5'd10, 32'h0, 32'h503, 32'h0), 1, 1, 32'h8012_3456, st, a, b, w);
    chk("lb_data", wb.rd_data, 32'hFFFF_FF80);
    chk("lb_stall", st, 2);

    // Reset while waiting for the response, then a stale rvalid.
    mem = mk(WB_MEM, 1'b0, BN_WORD, 1'b0, 5'd11, 32'h0, 32'h300, 32'h0);
    gnt = 1'b1; exp_stall = 1'b1; exp_req = 1'b1;
    exp_addr = 32'h300; exp_be = 4'hF; exp_wdata = 32'h0;
    @(negedge clk); @(posedge clk); #1;
    rstn = 1'b0; mem = '0; gnt = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rstn = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); @(posedge clk); #1;
    rvalid = 1'b0;
    chk("rst_wb_zero", wb, 32'd0);

    txn(mk(WB_MEM, 1'b0, BN_WORD, 1'b0, 5'd12, 32'h0, 32'h600, 32'h0), 0, 1, 32'h1357_9BDF, st, a, b, w);
    chk("post_rst_lw", wb.rd_data, 32'h1357_9BDF);

    txn(mk(WB_MEM, 1'b0, BN_WORD, 1'b0, 5'd13, 32'h0, 32'h102, 32'h0), 0, 1, 32'hAABB_CCDD, st, a, b, w);
`ifdef LSU_MISALIGN_CHK_EN
    chk("mis_wren", {31'd0, wb.rd_wren}, 32'd0);
    chk("mis_stall", st, 0);
`else
    chk("trunc_be", {28'd0, b}, 32'hC);
    chk("trunc_data", wb.rd_data, 32'h0000_AABB);
`endif

    mem = '0;
    @(negedge clk); @(posedge clk); #1;
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
